// File: rtl/acondicionador_entradas.sv
// Input conditioning for the turn-signal controller: synchronises and debounces
// the 2-bit turn lever and turns the hazard push-button into a toggling request.
module acondicionador_entradas #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] adi_raw,
    input  logic       btn_e_raw,
    output logic [1:0] ADI,
    output logic       E,
    output logic       e_pulse
);

    localparam int              CNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_PRESS = 2'd1,
        PRESSED    = 2'd2,
        WAIT_REL   = 2'd3
    } btn_state_t;

    logic [1:0]       r_adi_s1;
    logic [1:0]       r_adi_s2;
    logic [1:0]       r_adi_cand;
    logic [1:0]       r_adi_acc;
    logic [CNT_W-1:0] r_adi_cnt;

    logic             r_btn_s1;
    logic             r_btn_s2;
    btn_state_t       r_btn_state;
    logic [CNT_W-1:0] r_btn_cnt;
    logic             r_e;
    logic             r_e_pulse;

    logic [1:0]       w_adi_out;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_adi_s1 <= 2'b00;
            r_adi_s2 <= 2'b00;
            r_btn_s1 <= 1'b0;
            r_btn_s2 <= 1'b0;
        end else begin
            r_adi_s1 <= adi_raw;
            r_adi_s2 <= r_adi_s1;
            r_btn_s1 <= btn_e_raw;
            r_btn_s2 <= r_btn_s1;
        end
    end

    // The lever is debounced as a whole vector so a 01->10 swing cannot pass through 11 or 00.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_adi_cand <= 2'b00;
            r_adi_acc  <= 2'b00;
            r_adi_cnt  <= '0;
        end else if (r_adi_s2 != r_adi_cand) begin
            r_adi_cand <= r_adi_s2;
            r_adi_cnt  <= '0;
        end else if (r_adi_cnt == CNT_MAX) begin
            r_adi_acc  <= r_adi_cand;
        end else begin
            r_adi_cnt  <= r_adi_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn_state <= IDLE;
            r_btn_cnt   <= '0;
            r_e         <= 1'b0;
            r_e_pulse   <= 1'b0;
        end else begin
            r_e_pulse <= 1'b0;
            case (r_btn_state)
                IDLE: begin
                    if (r_btn_s2) begin
                        r_btn_state <= WAIT_PRESS;
                        r_btn_cnt   <= '0;
                    end
                end
                WAIT_PRESS: begin
                    if (!r_btn_s2) begin
                        r_btn_state <= IDLE;
                    end else if (r_btn_cnt == CNT_MAX) begin
                        r_btn_state <= PRESSED;
                        r_e         <= ~r_e;
                        r_e_pulse   <= 1'b1;
                    end else begin
                        r_btn_cnt   <= r_btn_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!r_btn_s2) begin
                        r_btn_state <= WAIT_REL;
                        r_btn_cnt   <= '0;
                    end
                end
                WAIT_REL: begin
                    if (r_btn_s2) begin
                        r_btn_state <= PRESSED;
                    end else if (r_btn_cnt == CNT_MAX) begin
                        r_btn_state <= IDLE;
                    end else begin
                        r_btn_cnt   <= r_btn_cnt + 1'b1;
                    end
                end
                default: begin
                    r_btn_state <= IDLE;
                    r_btn_cnt   <= '0;
                end
            endcase
        end
    end

    // 11 is not a legal lever position, so it is reported as "off".
    assign w_adi_out = (r_adi_acc == 2'b11) ? 2'b00 : r_adi_acc;

    assign ADI     = w_adi_out;
    assign E       = r_e;
    assign e_pulse = r_e_pulse;

endmodule

// File: tb/tb_acondicionador_entradas.sv
// Scoreboard bench for acondicionador_entradas: a window-based reference model
// predicts every output sample, and a monitor compares them as the DUT produces them.
module tb_acondicionador_entradas;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] adi_raw = 2'b00;
    logic       btn_e_raw = 1'b0;
    logic [1:0] ADI;
    logic       E;
    logic       e_pulse;

    typedef struct packed {
        logic [1:0] adi;
        logic       e;
        logic       pulse;
    } exp_t;

    exp_t expQ[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   started = 0;

    logic [1:0] levHist[$];
    logic       btnHist[$];
    logic [1:0] mAcc;
    logic       mDeb;
    logic       mE;
    logic       mPulse;

    acondicionador_entradas #(.DEB_CYCLES(DEB)) dut (
        .clk       (clk),
        .reset     (reset),
        .adi_raw   (adi_raw),
        .btn_e_raw (btn_e_raw),
        .ADI       (ADI),
        .E         (E),
        .e_pulse   (e_pulse)
    );

    always #5 clk = ~clk;

    // History holds the raw samples of the last DEB+3 edges; index DEB is the sample
    // taken two edges ago, which is what the debouncers see after synchronisation.
    function automatic void modelReset();
        levHist.delete();
        btnHist.delete();
        for (int i = 0; i < DEB + 3; i++) begin
            levHist.push_back(2'b00);
            btnHist.push_back(1'b0);
        end
        mAcc   = 2'b00;
        mDeb   = 1'b0;
        mE     = 1'b0;
        mPulse = 1'b0;
    endfunction

    // A value is accepted once DEB+1 consecutive synchronised samples agree on it.
    function automatic void modelEdge(input logic [1:0] adi, input logic btn);
        bit levStable;
        bit btnStable;
        levHist.push_back(adi);
        btnHist.push_back(btn);
        void'(levHist.pop_front());
        void'(btnHist.pop_front());
        levStable = 1;
        btnStable = 1;
        for (int i = 0; i <= DEB; i++) begin
            if (levHist[i] != levHist[DEB]) levStable = 0;
            if (btnHist[i] != btnHist[DEB]) btnStable = 0;
        end
        if (levStable) mAcc = levHist[DEB];
        mPulse = 1'b0;
        if (btnStable && (btnHist[DEB] != mDeb)) begin
            mDeb = btnHist[DEB];
            if (mDeb) begin
                mPulse = 1'b1;
                mE     = ~mE;
            end
        end
    endfunction

    function automatic exp_t modelOut();
        exp_t o;
        o.adi   = (mAcc == 2'b11) ? 2'b00 : mAcc;
        o.e     = mE;
        o.pulse = mPulse;
        return o;
    endfunction

    task automatic applyStimulus(input logic [1:0] adi, input logic btn,
                                 input logic rstN, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            adi_raw   = adi;
            btn_e_raw = btn;
            if (!rstN && reset) begin
                expQ.push_back('0);
                reset = 1'b0;
            end else if (rstN) begin
                reset = 1'b1;
            end
            if (!rstN) begin
                modelReset();
                expQ.push_back('0);
            end else begin
                modelEdge(adi, btn);
                expQ.push_back(modelOut());
            end
            @(negedge clk);
        end
    endtask

    task automatic checkOutput(input exp_t ex);
        vectors++;
        if (ADI !== ex.adi || E !== ex.e || e_pulse !== ex.pulse) begin
            miscompares++;
            $display("[TB] FAIL outputs t=%0t: got ADI=%b E=%b e_pulse=%b, expected ADI=%b E=%b e_pulse=%b",
                     $time, ADI, E, e_pulse, ex.adi, ex.e, ex.pulse);
        end
    endtask

    initial begin
        wait (started);
        forever begin
            @(posedge clk or negedge reset);
            #1;
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL scoreboard t=%0t: output sampled with no expectation queued", $time);
            end else begin
                checkOutput(expQ.pop_front());
            end
        end
    end

    initial begin
        modelReset();
        @(negedge clk);
        started = 1;
        #1;
        applyStimulus(2'b00, 1'b0, 1'b0, 3);
        applyStimulus(2'b00, 1'b0, 1'b1, 4);

        applyStimulus(2'b01, 1'b0, 1'b1, 10);
        applyStimulus(2'b00, 1'b0, 1'b1, 10);
        applyStimulus(2'b01, 1'b0, 1'b1, 3);
        applyStimulus(2'b00, 1'b0, 1'b1, 3);
        applyStimulus(2'b01, 1'b0, 1'b1, 3);
        applyStimulus(2'b00, 1'b0, 1'b1, 8);

        applyStimulus(2'b00, 1'b1, 1'b1, 20);
        applyStimulus(2'b00, 1'b0, 1'b1, 10);
        applyStimulus(2'b00, 1'b1, 1'b1, 20);
        applyStimulus(2'b00, 1'b0, 1'b1, 10);

        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b00, 1'b1, 1'b1, 2);
            applyStimulus(2'b00, 1'b0, 1'b1, 2);
        end
        applyStimulus(2'b00, 1'b1, 1'b1, 12);
        applyStimulus(2'b00, 1'b0, 1'b1, 10);

        applyStimulus(2'b11, 1'b0, 1'b1, 10);
        applyStimulus(2'b00, 1'b0, 1'b1, 8);
        applyStimulus(2'b10, 1'b1, 1'b1, 10);
        applyStimulus(2'b10, 1'b0, 1'b1, 10);

        applyStimulus(2'b10, 1'b1, 1'b1, 4);
        applyStimulus(2'b10, 1'b1, 1'b0, 3);
        applyStimulus(2'b00, 1'b0, 1'b1, 12);

        applyStimulus(2'b00, 1'b1, 1'b0, 2);
        applyStimulus(2'b00, 1'b1, 1'b1, 12);
        applyStimulus(2'b00, 1'b0, 1'b1, 8);

        for (int k = 0; k < 60; k++) begin
            applyStimulus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1,
                          int'($urandom_range(1, 8)));
        end
        applyStimulus(2'b01, 1'b1, 1'b0, 2);
        for (int k = 0; k < 30; k++) begin
            applyStimulus(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1,
                          int'($urandom_range(3, 10)));
        end

        for (int k = 0; k < 5 && expQ.size() != 0; k++) begin
            @(posedge clk);
            #2;
        end
        if (expQ.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
